// File: rtl/bslu_pkg.sv
// Shared definitions for the bit-serial logic unit: opcode values and FSM state encoding.
package bslu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_cell_1bit.sv
// One-bit logic cell: four gate primitives feeding a 4:1 select on the opcode.
module logic_cell_1bit
  import bslu_pkg::*;
(
  output logic       out1,
  input  logic       in1,
  input  logic       in2,
  input  logic [1:0] op
);

  logic g_and;
  logic g_or;
  logic g_xor;
  logic g_nor;

  and u_and (g_and, in1, in2);
  or  u_or  (g_or,  in1, in2);
  xor u_xor (g_xor, in1, in2);
  nor u_nor (g_nor, in1, in2);

  // Opcode selects which gate output drives the cell
  always_comb begin
    out1 = g_and;
    case (op)
      OP_AND:  out1 = g_and;
      OP_OR:   out1 = g_or;
      OP_XOR:  out1 = g_xor;
      OP_NOR:  out1 = g_nor;
      default: out1 = g_and;
    endcase
  end

endmodule

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial bitwise logic unit: accepts two operands and an opcode, streams them
// LSB-first through a 1-bit logic cell and holds the reassembled result until taken.
// Optional zero/parity result flags are built when BSLU_FLAGS_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a new operation (in_ready high)
//   SHIFT | one operand bit per cycle through the cell (busy high)
//   DONE  | out1 holds the result (out_valid high) until out_ready
module bit_serial_logic_unit
  import bslu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             busy
`ifdef BSLU_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [1:0]       op_r;
  // Only the upper WIDTH-1 result bits are kept: the LSB of a full shift
  // register would be shifted out on the final edge and never observed.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             cell_bit;

  logic_cell_1bit u_cell (
    .out1 (cell_bit),
    .in1  (a_sr[0]),
    .in2  (b_sr[0]),
    .op   (op_r)
  );

  assign res_next  = {cell_bit, res_sr};
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

  // Sequencer: capture, serial shift through the cell, result load and output hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      op_r   <= OP_AND;
      res_sr <= '0;
      out1   <= '0;
`ifdef BSLU_FLAGS_EN
      zero   <= 1'b1;
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= in1;
            b_sr  <= in2;
            op_r  <= op;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next[WIDTH-1:1];
          if (cnt == CNT_LAST) begin
            out1   <= res_next;
`ifdef BSLU_FLAGS_EN
            zero   <= ~|res_next;
            parity <= ^res_next;
`endif
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Randomized self-checking bench for bit_serial_logic_unit (WIDTH=8) against a
// word-level reference model. Flag checks are built when BSLU_FLAGS_EN is defined.
module tb_bit_serial_logic_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             busy;
`ifdef BSLU_FLAGS_EN
  logic             zero;
  logic             parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit_serial_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .busy      (busy)
`ifdef BSLU_FLAGS_EN
    ,
    .zero      (zero),
    .parity    (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check_flags(input string tag, input logic [WIDTH-1:0] r);
`ifdef BSLU_FLAGS_EN
    check({tag, "_zero"}, 32'(zero), 32'(r == '0));
    check({tag, "_parity"}, 32'(parity), 32'(^r));
`endif
  endtask

  // One full operation: issue, measure latency/busy, hold in DONE for 'stall' cycles, hand off.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] o, input int stall, input bit keep_valid);
    logic [WIDTH-1:0] exp;
    int lat;
    int busy_cnt;
    int w;
    bit saw_ready;
    exp = ref_op(a, b, o);
    @(negedge clk);
    in_valid = 1'b1; in1 = a; in2 = b; op = o; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    check({tag, "_ready_before_issue"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Captured values must be used, whatever the inputs do afterwards
    op = ~o;
    in1 = WIDTH'($urandom);
    in2 = WIDTH'($urandom);
    if (!keep_valid) in_valid = 1'b0;
    lat = 0; busy_cnt = 0; saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, "_ready_in_shift"}, 32'(saw_ready), 32'd0);
    check({tag, "_out1"}, 32'(out1), 32'(exp));
    check_flags(tag, exp);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd0);
      check({tag, "_hold_out1"}, 32'(out1), 32'(exp));
      check_flags({tag, "_hold"}, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_after_hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_after_hs_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_after_hs_out1"}, 32'(out1), 32'(exp));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin : main
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] e;
    int last_acc;
    int n_acc;

    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; op = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check_flags("rst", '0);
    rst_n = 1'b1;

    do_op("and_f0_3c", 8'hF0, 8'h3C, 2'b00, 0, 1'b0);
    do_op("xor_aa_aa", 8'hAA, 8'hAA, 2'b10, 5, 1'b1);
    do_op("nor_00_00", 8'h00, 8'h00, 2'b11, 0, 1'b0);

    // Reset pulse in the third SHIFT cycle of OR 0x0F,0xF0
    @(negedge clk);
    in_valid = 1'b1; in1 = 8'h0F; in2 = 8'hF0; op = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out1", 32'(out1), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check_flags("midrst", '0);
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_no_capture", 32'(busy), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_op("or_0f_10", 8'h0F, 8'h10, 2'b01, 0, 1'b0);
    do_op("and_ff_81", 8'hFF, 8'h81, 2'b00, 2, 1'b0);

    for (int k = 0; k < 10; k++)
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Streaming: in_valid and out_ready held high, inputs re-randomized while busy
    @(negedge clk);
    in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); op = 2'($urandom_range(0, 3));
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) check("stream_unexpected_result", 32'(out1), 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          check("stream_out1", 32'(out1), 32'(e));
          check_flags("stream", e);
        end
      end
      if (in_ready) begin
        if (last_acc >= 0) check("stream_interval", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc = cyc;
        n_acc++;
        q.push_back(ref_op(in1, in2, op));
      end else begin
        in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); op = 2'($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid && q.size() > 0) begin
        e = q.pop_front();
        check("drain_out1", 32'(out1), 32'(e));
      end
    end
    check("stream_accepts", 32'(n_acc), 32'd8);
    check("stream_drained", 32'(q.size()), 32'd0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
